// File: rtl/seq_alu_if.sv
// Handshake and data bundle between the multi-cycle controller (master)
// and the registered sequential ALU (slave).
interface seq_alu_if #(
  parameter int W       = 24,
  parameter int OP_BITS = 4
);
  logic               start;
  logic [OP_BITS-1:0] ALU_OP;
  logic [W-1:0]       a;
  logic [W-1:0]       b;
  logic               busy;
  logic               done;
  logic [W-1:0]       result;
  logic               Z;
  logic               C;
  logic               N;
  logic               V;
  logic               ill_op;

  modport master (
    output start, ALU_OP, a, b,
    input  busy, done, result, Z, C, N, V, ill_op
  );

  modport slave (
    input  start, ALU_OP, a, b,
    output busy, done, result, Z, C, N, V, ill_op
  );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU: one operation per start/done handshake. Single-cycle ops
// finish on the next edge; MUL is an iterative shift-add over W cycles.
// Result, flags and ill_op are written only when entering DONE and hold
// until the next operation completes.
module seq_alu #(
  parameter int DATA_BUS_WIDTH  = 24,
  parameter int ALU_OP_NUM_BITS = 4,
  parameter int SHAMT_BITS      = 5
) (
  input logic       clk,
  input logic       reset,
  seq_alu_if.slave  bus
);
  localparam int W     = DATA_BUS_WIDTH;
  localparam int CNT_W = $clog2(W);

  localparam logic [ALU_OP_NUM_BITS-1:0] OP_ADD  = ALU_OP_NUM_BITS'(0);
  localparam logic [ALU_OP_NUM_BITS-1:0] OP_SUB  = ALU_OP_NUM_BITS'(1);
  localparam logic [ALU_OP_NUM_BITS-1:0] OP_AND  = ALU_OP_NUM_BITS'(2);
  localparam logic [ALU_OP_NUM_BITS-1:0] OP_OR   = ALU_OP_NUM_BITS'(3);
  localparam logic [ALU_OP_NUM_BITS-1:0] OP_XOR  = ALU_OP_NUM_BITS'(4);
  localparam logic [ALU_OP_NUM_BITS-1:0] OP_NOT  = ALU_OP_NUM_BITS'(5);
  localparam logic [ALU_OP_NUM_BITS-1:0] OP_INCR = ALU_OP_NUM_BITS'(6);
  localparam logic [ALU_OP_NUM_BITS-1:0] OP_SHL  = ALU_OP_NUM_BITS'(7);
  localparam logic [ALU_OP_NUM_BITS-1:0] OP_SHR  = ALU_OP_NUM_BITS'(8);
  localparam logic [ALU_OP_NUM_BITS-1:0] OP_MUL  = ALU_OP_NUM_BITS'(9);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [W-1:0]       result_q, result_d;
  logic               z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;
  logic               ill_q, ill_d;
  logic [2*W-1:0]     acc_q, acc_d;
  logic [2*W-1:0]     mcand_q, mcand_d;
  logic [W-1:0]       mplier_q, mplier_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [W-1:0]       alu_res;
  logic               alu_c, alu_v, alu_ill;
  logic [W:0]         sum;
  logic [W:0]         sh_ext;
  logic [SHAMT_BITS-1:0] sh;
  logic [2*W-1:0]     partial;

  // Single-cycle datapath evaluated directly on the live operands at accept
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    sum     = '0;
    sh_ext  = '0;
    sh      = bus.b[SHAMT_BITS-1:0];
    case (bus.ALU_OP)
      OP_ADD: begin
        sum     = {1'b0, bus.a} + {1'b0, bus.b};
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (bus.a[W-1] == bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
      end
      OP_SUB: begin
        sum     = {1'b0, bus.a} + {1'b0, ~bus.b} + (W+1)'(1);
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (bus.a[W-1] != bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_NOT:  alu_res = ~bus.a;
      OP_INCR: begin
        sum     = {1'b0, bus.a} + (W+1)'(1);
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (bus.a == {1'b0, {(W-1){1'b1}}});
      end
      OP_SHL: begin
        if (sh == '0) begin
          alu_res = bus.a;
        end else if (32'(sh) < DATA_BUS_WIDTH) begin
          sh_ext  = {1'b0, bus.a} << sh;
          alu_res = sh_ext[W-1:0];
          alu_c   = sh_ext[W];
        end
      end
      OP_SHR: begin
        if (sh == '0) begin
          alu_res = bus.a;
        end else if (32'(sh) < DATA_BUS_WIDTH) begin
          sh_ext  = {bus.a, 1'b0} >> sh;
          alu_res = sh_ext[W:1];
          alu_c   = sh_ext[0];
        end
      end
      OP_MUL:  alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // Next-state logic for the IDLE/MUL/DONE controller and the multiplier
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = done_q;
    result_d = result_q;
    z_d      = z_q;
    c_d      = c_q;
    n_d      = n_q;
    v_d      = v_q;
    ill_d    = ill_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    partial  = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.ALU_OP == OP_MUL) begin
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, bus.a};
            mplier_d = bus.b;
            count_d  = '0;
            busy_d   = 1'b1;
            state_d  = S_MUL;
          end else begin
            result_d = alu_res;
            z_d      = (alu_res == '0);
            c_d      = alu_c;
            n_d      = alu_res[W-1];
            v_d      = alu_v;
            ill_d    = alu_ill;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d    = partial;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CNT_W'(1);
        if (count_q == CNT_W'(W-1)) begin
          result_d = partial[W-1:0];
          z_d      = (partial[W-1:0] == '0);
          c_d      = |partial[2*W-1:W];
          n_d      = partial[W-1];
          v_d      = 1'b0;
          ill_d    = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any multiply in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      z_q      <= 1'b1;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      ill_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      z_q      <= z_d;
      c_q      <= c_d;
      n_q      <= n_d;
      v_q      <= v_d;
      ill_q    <= ill_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.Z      = z_q;
  assign bus.C      = c_q;
  assign bus.N      = n_q;
  assign bus.V      = v_q;
  assign bus.ill_op = ill_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at W=24: hand-computed vectors for every opcode
// class, handshake latency, reset mid-multiply and ignored starts.
module tb_seq_alu;
  logic clk;
  logic reset;
  int   checkCount;
  int   passCount;
  int   lat;
  int   busyCycles;
  int   extraDones;

  seq_alu_if #(.W(24), .OP_BITS(4)) bus();

  seq_alu #(
    .DATA_BUS_WIDTH (24),
    .ALU_OP_NUM_BITS(4),
    .SHAMT_BITS     (5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if it differs
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Issue one request for a single cycle, then wait (bounded) for done
  task automatic applyStimulus(input logic [3:0] op, input logic [23:0] aIn, input logic [23:0] bIn,
                               output int latency, output int busyCnt);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.ALU_OP = op;
    bus.a      = aIn;
    bus.b      = bIn;
    @(negedge clk);
    bus.start = 1'b0;
    latency   = 1;
    busyCnt   = 0;
    while (bus.done !== 1'b1 && latency < 64) begin
      if (bus.busy === 1'b1) busyCnt++;
      @(negedge clk);
      latency++;
    end
  endtask

  // Compare latency, result and {Z,C,N,V,ill_op} of a completed operation
  task automatic checkAlu(input string tag, input int expLat, input logic [23:0] expRes, input logic [4:0] expFlags);
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, " result"}, {8'h0, bus.result}, {8'h0, expRes});
    checkOutput({tag, " ZCNVI"}, {27'h0, bus.Z, bus.C, bus.N, bus.V, bus.ill_op}, {27'h0, expFlags});
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.ALU_OP = '0;
    bus.a      = '0;
    bus.b      = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    checkOutput("reset busy", {31'h0, bus.busy}, 32'h0);
    checkOutput("reset done", {31'h0, bus.done}, 32'h0);
    checkOutput("reset result", {8'h0, bus.result}, 32'h0);
    checkOutput("reset ZCNVI", {27'h0, bus.Z, bus.C, bus.N, bus.V, bus.ill_op}, 32'h10);

    applyStimulus(4'd0, 24'hFFFFFF, 24'h000001, lat, busyCycles);
    checkAlu("ADD wrap", 1, 24'h000000, 5'b11000);
    @(negedge clk);
    checkOutput("done one cycle", {31'h0, bus.done}, 32'h0);
    checkOutput("result hold", {8'h0, bus.result}, 32'h0);

    applyStimulus(4'd0, 24'h7FFFFF, 24'h000001, lat, busyCycles);
    checkAlu("ADD ovf", 1, 24'h800000, 5'b00110);
    applyStimulus(4'd1, 24'h000005, 24'h000007, lat, busyCycles);
    checkAlu("SUB borrow", 1, 24'hFFFFFE, 5'b00100);
    applyStimulus(4'd1, 24'h000007, 24'h000005, lat, busyCycles);
    checkAlu("SUB noborrow", 1, 24'h000002, 5'b01000);
    applyStimulus(4'd6, 24'h7FFFFF, 24'h000000, lat, busyCycles);
    checkAlu("INCR ovf", 1, 24'h800000, 5'b00110);
    applyStimulus(4'd2, 24'hF0F0F0, 24'hFF00FF, lat, busyCycles);
    checkAlu("AND", 1, 24'hF000F0, 5'b00100);
    applyStimulus(4'd3, 24'hF0F0F0, 24'hFF00FF, lat, busyCycles);
    checkAlu("OR", 1, 24'hFFF0FF, 5'b00100);
    applyStimulus(4'd4, 24'hF0F0F0, 24'hFF00FF, lat, busyCycles);
    checkAlu("XOR", 1, 24'h0FF00F, 5'b00000);
    applyStimulus(4'd5, 24'hF0F0F0, 24'h000000, lat, busyCycles);
    checkAlu("NOT", 1, 24'h0F0F0F, 5'b00000);

    applyStimulus(4'd9, 24'h001234, 24'h000100, lat, busyCycles);
    checkAlu("MUL basic", 25, 24'h123400, 5'b00000);
    checkOutput("MUL busy cycles", 32'(busyCycles), 32'd24);
    applyStimulus(4'd9, 24'h800000, 24'h000002, lat, busyCycles);
    checkAlu("MUL high", 25, 24'h000000, 5'b11000);
    applyStimulus(4'd9, 24'h000FFF, 24'h000FFF, lat, busyCycles);
    checkAlu("MUL square", 25, 24'hFFE001, 5'b00100);

    applyStimulus(4'd8, 24'h000003, 24'h000001, lat, busyCycles);
    checkAlu("SHR 1", 1, 24'h000001, 5'b01000);
    applyStimulus(4'd8, 24'hABCDEF, 24'h000018, lat, busyCycles);
    checkAlu("SHR 24", 1, 24'h000000, 5'b10000);
    applyStimulus(4'd7, 24'h000001, 24'h000017, lat, busyCycles);
    checkAlu("SHL 23", 1, 24'h800000, 5'b00100);
    applyStimulus(4'd7, 24'h123456, 24'h000020, lat, busyCycles);
    checkAlu("SHL sh0", 1, 24'h123456, 5'b00000);
    applyStimulus(4'd7, 24'h800001, 24'h000001, lat, busyCycles);
    checkAlu("SHL 1", 1, 24'h000002, 5'b01000);

    // Reset arriving mid-multiply
    @(negedge clk);
    bus.start  = 1'b1;
    bus.ALU_OP = 4'd9;
    bus.a      = 24'h001234;
    bus.b      = 24'h000100;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("MUL accept busy", {31'h0, bus.busy}, 32'h1);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset busy", {31'h0, bus.busy}, 32'h0);
    checkOutput("midreset done", {31'h0, bus.done}, 32'h0);
    checkOutput("midreset result", {8'h0, bus.result}, 32'h0);
    checkOutput("midreset ZCNVI", {27'h0, bus.Z, bus.C, bus.N, bus.V, bus.ill_op}, 32'h10);
    applyStimulus(4'd0, 24'h000002, 24'h000003, lat, busyCycles);
    checkAlu("ADD after reset", 1, 24'h000005, 5'b00000);

    // Starts while busy and while done must be ignored
    @(negedge clk);
    bus.start  = 1'b1;
    bus.ALU_OP = 4'd9;
    bus.a      = 24'h000003;
    bus.b      = 24'h000005;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 64) begin
      if (lat == 5) begin
        bus.start  = 1'b1;
        bus.ALU_OP = 4'd0;
        bus.a      = 24'h000001;
        bus.b      = 24'h000001;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    checkAlu("MUL ignore busy", 25, 24'h00000F, 5'b00000);
    bus.start  = 1'b1;
    bus.ALU_OP = 4'd0;
    bus.a      = 24'h000001;
    bus.b      = 24'h000001;
    @(negedge clk);
    bus.start  = 1'b0;
    extraDones = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.done === 1'b1) extraDones++;
      @(negedge clk);
    end
    checkOutput("ignored starts", 32'(extraDones), 32'd0);
    checkOutput("ignored result", {8'h0, bus.result}, 32'h00000F);

    applyStimulus(4'hF, 24'h123456, 24'h654321, lat, busyCycles);
    checkAlu("illegal op", 1, 24'h000000, 5'b10001);
    applyStimulus(4'd0, 24'h000001, 24'h000001, lat, busyCycles);
    checkAlu("ill clears", 1, 24'h000002, 5'b00000);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
